// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks in-flight writers after ID and produces stall/flush/forward controls.
// Build option HAZARD_FORWARD_EN: forward from EX/MEM and stall only on load-use; otherwise stall on any RAW match.
module hazard_scoreboard #(
   parameter int REG_AW  = 5,
   parameter int DEPTH   = 3,
   parameter int BR_SLOT = 1,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic              id_wr_en,
   input  logic [REG_AW-1:0] id_wr_dst,
   input  logic              id_is_load,
   input  logic              br_taken,
   output logic              stall,
   output logic              flush,
   output logic [2:0]        fwd_a,
   output logic [2:0]        fwd_b,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   typedef struct packed {
      logic              valid;
      logic              wr_en;
      logic [REG_AW-1:0] dst;
      logic              is_load;
   } slot_t;

   slot_t             slot_q [DEPTH];
   slot_t             slot_d [DEPTH];
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic [DEPTH-2:0]  hit_a, hit_b;

   // WB (slot DEPTH-1) is never compared: the register file already holds its result for ID.
   always_comb begin
      hit_a = '0;
      hit_b = '0;
      for (int i = 0; i < DEPTH - 1; i++) begin
         hit_a[i] = id_valid && id_use_rs && (id_rs != '0) && slot_q[i].valid &&
                    slot_q[i].wr_en && (slot_q[i].dst == id_rs);
         hit_b[i] = id_valid && id_use_rt && (id_rt != '0) && slot_q[i].valid &&
                    slot_q[i].wr_en && (slot_q[i].dst == id_rt);
      end
   end

   assign flush = br_taken;

`ifdef HAZARD_FORWARD_EN
   always_comb begin
      stall = (hit_a[0] || hit_b[0]) && slot_q[0].is_load && !br_taken;
      fwd_a = '0;
      fwd_b = '0;
      // Scan oldest to youngest so the youngest matching slot overrides.
      for (int i = DEPTH - 2; i >= 0; i--) begin
         if (hit_a[i]) fwd_a = 3'(i + 1);
         if (hit_b[i]) fwd_b = 3'(i + 1);
      end
   end
`else
   always_comb begin
      stall = ((|hit_a) || (|hit_b)) && !br_taken;
      fwd_a = '0;
      fwd_b = '0;
   end
`endif

   always_comb begin
      slot_d[0] = '0;
      if (id_valid && !stall && !flush) begin
         slot_d[0].valid   = 1'b1;
         slot_d[0].wr_en   = id_wr_en;
         slot_d[0].dst     = id_wr_dst;
         slot_d[0].is_load = id_is_load;
      end
      for (int i = 1; i < DEPTH; i++) begin
         slot_d[i] = slot_q[i-1];
         if (flush && (i <= BR_SLOT)) slot_d[i].valid = 1'b0;
      end

      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      flush_cnt_d = flush_cnt_q;
      if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      if (rst) begin
         // NOTE: only valid bits are reset; payload fields are don't-care while invalid.
         for (int i = 0; i < DEPTH; i++) slot_q[i].valid <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard; expectations follow HAZARD_FORWARD_EN when defined.
module tb_hazard_scoreboard;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             id_valid;
   logic [4:0]       id_rs, id_rt;
   logic             id_use_rs, id_use_rt;
   logic             id_wr_en;
   logic [4:0]       id_wr_dst;
   logic             id_is_load;
   logic             br_taken;
   logic             stall, flush;
   logic [2:0]       fwd_a, fwd_b;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   int checks   = 0;
   int failures = 0;

   hazard_scoreboard #(.REG_AW(5), .DEPTH(3), .BR_SLOT(1), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .id_valid   (id_valid),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_use_rs  (id_use_rs),
      .id_use_rt  (id_use_rt),
      .id_wr_en   (id_wr_en),
      .id_wr_dst  (id_wr_dst),
      .id_is_load (id_is_load),
      .br_taken   (br_taken),
      .stall      (stall),
      .flush      (flush),
      .fwd_a      (fwd_a),
      .fwd_b      (fwd_b),
      .stall_cnt  (stall_cnt),
      .flush_cnt  (flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic we,
                         input logic [4:0] dst, input logic ld);
      id_valid   = v;
      id_rs      = rs;
      id_rt      = rt;
      id_use_rs  = urs;
      id_use_rt  = urt;
      id_wr_en   = we;
      id_wr_dst  = dst;
      id_is_load = ld;
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      br_taken = 1'b0;
      set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      // Reset state, with a valid ID instruction (add r3 = r1 + r2) already presented
      do_reset();
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0);
      check("rst_stall", stall, 0);
      check("rst_flush", flush, 0);
      check("rst_fwd_a", fwd_a, 0);
      check("rst_fwd_b", fwd_b, 0);
      check("rst_stall_cnt", stall_cnt, 0);
      check("rst_flush_cnt", flush_cnt, 0);
      tick();

      // add r3 in EX; ID reads r3 (writes r6)
      set_id(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0);
`ifdef HAZARD_FORWARD_EN
      check("raw_ex_stall", stall, 0);
      check("raw_ex_fwd_a", fwd_a, 1);
      check("raw_ex_fwd_b", fwd_b, 0);
      tick();
      set_id(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
      check("raw_mem_stall", stall, 0);
      check("raw_mem_fwd_a", fwd_a, 2);
      check("raw_stall_cnt", stall_cnt, 0);
      tick();
`else
      check("raw_ex_stall", stall, 1);
      check("raw_ex_fwd_a", fwd_a, 0);
      tick();
      check("raw_mem_stall", stall, 1);
      tick();
      check("raw_wb_stall", stall, 0);
      check("raw_wb_fwd_a", fwd_a, 0);
      check("raw_stall_cnt", stall_cnt, 2);
      tick();
`endif

`ifdef HAZARD_FORWARD_EN
      // Two writers of r3 in flight: youngest (EX) wins
      do_reset();
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0);
      tick();
      set_id(1'b1, 5'd4, 5'd5, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0);
      tick();
      set_id(1'b1, 5'd7, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
      check("young_fwd_b", fwd_b, 1);
      check("young_stall", stall, 0);
      tick();
`endif

      // Load-use: lw r5 in EX, ID reads rt=r5
      do_reset();
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1);
      tick();
      set_id(1'b1, 5'd7, 5'd5, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0);
      check("lu_stall1", stall, 1);
      tick();
`ifdef HAZARD_FORWARD_EN
      check("lu_stall2", stall, 0);
      check("lu_fwd_b", fwd_b, 2);
      check("lu_stall_cnt", stall_cnt, 1);
`else
      check("lu_stall2", stall, 1);
      tick();
      check("lu_stall3", stall, 0);
      check("lu_fwd_b", fwd_b, 0);
      check("lu_stall_cnt", stall_cnt, 2);
`endif
      tick();

      // Register 0 is never a hazard
      do_reset();
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0);
      tick();
      set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
      check("r0_stall", stall, 0);
      check("r0_fwd_a", fwd_a, 0);
      check("r0_fwd_b", fwd_b, 0);
      tick();
      check("r0_mem_stall", stall, 0);
      tick();

      // Unused sources do not match
      do_reset();
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0);
      tick();
      set_id(1'b1, 5'd9, 5'd9, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      check("nouse_stall", stall, 0);
      check("nouse_fwd_a", fwd_a, 0);
      tick();

      // Branch taken with a dependent lw in EX: flush wins, slot 0 squashed
      do_reset();
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1);
      tick();
      set_id(1'b1, 5'd7, 5'd5, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0);
      br_taken = 1'b1;
      #1;
      check("br_flush", flush, 1);
      check("br_stall", stall, 0);
      tick();
      br_taken = 1'b0;
      #1;
      check("br_after_flush", flush, 0);
      check("br_squash_stall", stall, 0);
      check("br_squash_fwd_b", fwd_b, 0);
      check("br_flush_cnt", flush_cnt, 1);
      check("br_stall_cnt", stall_cnt, 0);
      tick();

      // Reset in the middle of a RAW stall
      do_reset();
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0);
      tick();
      set_id(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0);
`ifdef HAZARD_FORWARD_EN
      check("mid_pre_stall", stall, 0);
`else
      check("mid_pre_stall", stall, 1);
`endif
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("mid_stall", stall, 0);
      check("mid_fwd_a", fwd_a, 0);
      check("mid_fwd_b", fwd_b, 0);
      check("mid_stall_cnt", stall_cnt, 0);
      check("mid_flush_cnt", flush_cnt, 0);
      tick();

      // Counter saturation: 20 flush cycles into a 4-bit counter
      do_reset();
      br_taken = 1'b1;
      repeat (20) tick();
      check("sat_flush_cnt", flush_cnt, 15);
      br_taken = 1'b0;
      #1;
      check("sat_flush_low", flush, 0);
      tick();
      check("sat_flush_hold", flush_cnt, 15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
